set_cmd_issuer: RTL and testbench

Host-side initiator for the SET lattice-point counting engine. Accepts commands on a valid/ready stream, queues them, and drives the SET command port (`en`, `central`, `radius`, `mode`) one transaction at a time. It then collects `candidate` on the SET `valid` pulse and returns it, tagged, on a valid/ready result stream. A watchdog turns a missing `valid` into a timeout result so the host never hangs.

---
 rtl/set_pkg.sv | 25 ++
 rtl/set_cmd_fifo.sv | 55 +++++
 rtl/set_cmd_issuer.sv | 118 +++++++++++
 tb/tb_set_cmd_issuer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// Shared widths, SET mode encodings and issuer types for the SET command issuer.
package set_pkg;

    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int TAG_W     = 4;
    localparam int ENTRY_W   = CENTRAL_W + RADIUS_W + MODE_W + TAG_W;

    localparam logic [MODE_W-1:0] MODE_A   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_AB  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_AXB = 2'd2;
    localparam logic [MODE_W-1:0] MODE_RSV = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} issuer_state_t;

    // One queued command; packed so it maps directly onto a FIFO entry.
    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
        logic [TAG_W-1:0]     tag;
    } set_cmd_t;

endpackage

// File: rtl/set_cmd_fifo.sv
// Synchronous show-ahead FIFO holding pending SET commands.
module set_cmd_fifo
    import set_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wr_data,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/set_cmd_issuer.sv
// Host-side SET initiator: queues commands, issues one at a time, returns
// tagged results, and converts a missing SET valid into a timeout result.
module set_cmd_issuer
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CENTRAL_W-1:0] cmd_central,
    input  logic [RADIUS_W-1:0]  cmd_radius,
    input  logic [MODE_W-1:0]    cmd_mode,
    input  logic [TAG_W-1:0]     cmd_tag,
    output logic                 en,
    output logic [CENTRAL_W-1:0] central,
    output logic [RADIUS_W-1:0]  radius,
    output logic [MODE_W-1:0]    mode,
    input  logic                 busy,
    input  logic                 valid,
    input  logic [7:0]           candidate,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [7:0]           res_candidate,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 res_timeout
);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    set_cmd_t                 in_cmd;
    set_cmd_t                 head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_level_unused;
    logic                     pop;
    issuer_state_t            state;
    logic [TAG_W-1:0]         tag_q;
    logic [7:0]               wdog;

    assign in_cmd    = '{central: cmd_central, radius: cmd_radius, mode: cmd_mode, tag: cmd_tag};
    assign cmd_ready = !fifo_full;
    // Only IDLE may start a transaction, which keeps one outstanding at a time.
    assign pop       = (state == IDLE) && !fifo_empty && !busy;

    set_cmd_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid),
        .pop     (pop),
        .wr_data (in_cmd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level_unused)
    );

    // Issue/wait/return sequencer with watchdog; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            en            <= 1'b0;
            central       <= '0;
            radius        <= '0;
            mode          <= '0;
            tag_q         <= '0;
            wdog          <= '0;
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_tag       <= '0;
            res_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        central <= head.central;
                        radius  <= head.radius;
                        mode    <= head.mode;
                        tag_q   <= head.tag;
                        en      <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    en    <= 1'b0;
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (valid) begin
                        res_candidate <= candidate;
                        res_tag       <= tag_q;
                        res_timeout   <= 1'b0;
                        res_valid     <= 1'b1;
                        state         <= OUTPUT;
                    end else if (wdog == TIMEOUT_LIM) begin
                        res_candidate <= '0;
                        res_tag       <= tag_q;
                        res_timeout   <= 1'b1;
                        res_valid     <= 1'b1;
                        state         <= OUTPUT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_cmd_issuer.sv
// Directed + randomized bench for set_cmd_issuer with an in-order command
// queue as reference model and a scripted SET responder.
module tb_set_cmd_issuer;
    import set_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [CENTRAL_W-1:0] cmd_central = '0;
    logic [RADIUS_W-1:0]  cmd_radius = '0;
    logic [MODE_W-1:0]    cmd_mode = '0;
    logic [TAG_W-1:0]     cmd_tag = '0;
    logic                 en;
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
    logic                 busy = 1'b0;
    logic                 valid = 1'b0;
    logic [7:0]           candidate = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [7:0]           res_candidate;
    logic [TAG_W-1:0]     res_tag;
    logic                 res_timeout;

    int n_chk  = 0;
    int n_fail = 0;
    set_cmd_t exp_q[$];

    set_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_central(cmd_central), .cmd_radius(cmd_radius),
        .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
        .en(en), .central(central), .radius(radius), .mode(mode),
        .busy(busy), .valid(valid), .candidate(candidate),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_candidate(res_candidate), .res_tag(res_tag),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no end, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic set_cmd_t mk(input logic [TAG_W-1:0] t);
        set_cmd_t c;
        c.central = CENTRAL_W'($urandom);
        c.radius  = RADIUS_W'($urandom);
        c.mode    = MODE_W'($urandom);
        c.tag     = t;
        return c;
    endfunction

    // Offer one command; waits (bounded) for space, then one handshake cycle.
    task automatic push_cmd(input set_cmd_t c);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
        chk("push_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_central = c.central; cmd_radius = c.radius;
        cmd_mode = c.mode; cmd_tag = c.tag;
        step();
        cmd_valid = 1'b0;
        exp_q.push_back(c);
    endtask

    // Wait for the en pulse, check issued fields, step into WAIT.
    task automatic wait_issue(input int budget);
        int n = 0;
        while (en !== 1'b1 && n < budget) begin step(); n++; end
        chk("en_seen", en, 1);
        if (en === 1'b1) begin
            chk("issue_central", central, exp_q[0].central);
            chk("issue_radius", radius, exp_q[0].radius);
            chk("issue_mode", mode, exp_q[0].mode);
            step();
            chk("en_one_cycle", en, 0);
            chk("central_hold", central, exp_q[0].central);
            chk("radius_hold", radius, exp_q[0].radius);
        end
    endtask

    // SET side: answer after lat idle cycles, or never (watchdog case).
    task automatic respond(input int lat, input logic [7:0] cand, input bit give);
        if (give) begin
            repeat (lat) begin
                candidate = 8'($urandom);
                step();
                chk("no_early_res", res_valid, 0);
            end
            valid = 1'b1; candidate = cand;
            step();
            valid = 1'b0; candidate = 8'($urandom);
            chk("res_valid_rise", res_valid, 1);
        end else begin
            for (int i = 0; i < TIMEOUT; i++) begin
                step();
                chk("wd_quiet", res_valid, 0);
            end
            step();
            chk("wd_fire", res_valid, 1);
            valid = 1'b1; candidate = 8'hAA;
            step();
            valid = 1'b0;
            chk("late_valid_cand", res_candidate, 0);
            chk("late_valid_to", res_timeout, 1);
        end
    endtask

    // Check the result against the model head, hold backpressure, handshake.
    task automatic collect(input int hold, input logic [7:0] cand, input bit to);
        chk("res_valid", res_valid, 1);
        chk("res_candidate", res_candidate, cand);
        chk("res_tag", res_tag, exp_q[0].tag);
        chk("res_timeout", res_timeout, to);
        repeat (hold) begin
            step();
            chk("hold_valid", res_valid, 1);
            chk("hold_cand", res_candidate, cand);
            chk("hold_tag", res_tag, exp_q[0].tag);
            chk("hold_no_en", en, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        void'(exp_q.pop_front());
    endtask

    initial begin
        set_cmd_t c;
        logic [7:0] cand;

        // Reset state
        #3;
        chk("rst_en", en, 0);
        chk("rst_central", central, 0);
        chk("rst_radius", radius, 0);
        chk("rst_mode", mode, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_cand", res_candidate, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_res_to", res_timeout, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        step(); step();
        rst_n = 1'b1;
        step();

        // Single command, nominal result 29
        c = '{central: 24'h440000, radius: 12'h300, mode: MODE_A, tag: 4'd5};
        push_cmd(c);
        chk("single_en_not_yet", en, 0);
        step();
        chk("single_en_edge1", en, 1);
        wait_issue(0);
        respond(5, 8'd29, 1'b1);
        collect(0, 8'd29, 1'b0);

        // Backpressure with a second command queued behind
        push_cmd(mk(4'd1));
        push_cmd(mk(4'd2));
        wait_issue(10);
        cand = 8'($urandom);
        respond(3, cand, 1'b1);
        collect(20, cand, 1'b0);
        chk("bp_idle_gap", en, 0);
        step();
        chk("bp_next_en", en, 1);
        wait_issue(0);
        cand = 8'($urandom);
        respond(1, cand, 1'b1);
        collect(2, cand, 1'b0);

        // Fill with SET stalled on busy
        busy = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(mk(4'(i)));
        chk("fill_full", cmd_ready, 0);
        c = mk(4'd4);
        cmd_valid = 1'b1; cmd_central = c.central; cmd_radius = c.radius;
        cmd_mode = c.mode; cmd_tag = c.tag;
        busy = 1'b0;
        step();
        chk("fill_ready_after_pop", cmd_ready, 1);
        chk("fill_en", en, 1);
        chk("fill_head_central", central, exp_q[0].central);
        step();
        cmd_valid = 1'b0;
        exp_q.push_back(c);
        chk("fill_en_drop", en, 0);
        cand = 8'($urandom);
        respond(2, cand, 1'b1);
        collect(0, cand, 1'b0);
        for (int i = 1; i < 5; i++) begin
            wait_issue(20);
            cand = 8'($urandom);
            respond(i, cand, 1'b1);
            collect(1, cand, 1'b0);
        end

        // Busy gate
        busy = 1'b1;
        push_cmd(mk(4'd9));
        repeat (5) begin step(); chk("busy_hold_en", en, 0); end
        busy = 1'b0;
        step();
        chk("busy_release_en", en, 1);
        wait_issue(0);
        cand = 8'($urandom);
        respond(0, cand, 1'b1);
        collect(0, cand, 1'b0);

        // Watchdog timeout, late valid ignored
        push_cmd(mk(4'd11));
        wait_issue(10);
        respond(0, 8'd0, 1'b0);
        collect(1, 8'd0, 1'b1);

        // Randomized transactions, includes reserved mode 3
        for (int i = 0; i < 10; i++) begin
            c = mk(4'($urandom));
            if (i == 0) c.mode = MODE_RSV;
            push_cmd(c);
            wait_issue(10);
            cand = 8'($urandom);
            respond(int'($urandom_range(0, 8)), cand, 1'b1);
            collect(int'($urandom_range(0, 3)), cand, 1'b0);
        end

        // Reset mid-WAIT with another command queued
        push_cmd(mk(4'd7));
        wait_issue(10);
        push_cmd(mk(4'd8));
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_en", en, 0);
        chk("arst_central", central, 0);
        chk("arst_radius", radius, 0);
        chk("arst_mode", mode, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        valid = 1'b1; candidate = 8'h55;
        step();
        valid = 1'b0;
        repeat (6) begin
            step();
            chk("post_rst_no_en", en, 0);
            chk("post_rst_no_res", res_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
